alu_sequencer: RTL and testbench

- Sequencer placed in front of the CU/ALU datapath. CU takes a 19-bit word: opcode [18:16], operand1 [15:8], operand2 [7:0]. CU returns an 8-bit combinational result.
- Queues instructions from a producer in a small FIFO and issues them to the CU one at a time.
- Holds each CU word stable for a programmable settle time, then registers the result into an output register and an accumulator.
- Presents the result on a valid/ready interface. Optional accumulator chaining allows multi-step computations.

---
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Front-end sequencer for the CU/ALU datapath. Instructions from a producer
//   are queued in a small FIFO and issued to the CU one at a time. Each CU
//   word is held stable for SETTLE_CYCLES cycles, then the CU result is
//   captured into an output register and an accumulator and offered on a
//   valid/ready interface. An instruction may take operand1 from the
//   accumulator to chain computations.
//
// Ports
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   in_valid      : producer presents in_instr
//   in_ready      : FIFO has room (depends on fullness only)
//   in_instr[19:0]: {acc_src, opcode[2:0], operand1[7:0], operand2[7:0]}
//   cu_in[18:0]   : registered word to the CU {opcode, operand1, operand2}
//   cu_result[7:0]: combinational CU result
//   out_valid     : out_result/out_op are valid
//   out_ready     : consumer accepts the result
//   out_result    : captured CU result
//   out_op        : opcode that produced out_result
//   acc           : accumulator (last captured result)
//   busy          : FSM not idle or FIFO not empty
//   fifo_count    : number of queued instructions
module alu_sequencer #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [19:0]              in_instr,
  output logic [18:0]              cu_in,
  input  logic [7:0]               cu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_result,
  output logic [2:0]               out_op,
  output logic [7:0]               acc,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  // The counter only has to hold SETTLE_CYCLES-1.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [19:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              push, pop, capture, fifo_empty;
  logic [19:0]       head;

  // Build the CU word from a queued instruction; acc_src swaps operand1
  // for the current accumulator value.
  function automatic logic [18:0] cu_word(input logic [19:0] instr,
                                          input logic [7:0]  acc_val);
    logic [7:0] op1;
    op1 = instr[19] ? acc_val : instr[15:8];
    return {instr[18:16], op1, instr[7:0]};
  endfunction

  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = (fifo_count != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // out_valid is always set in DONE, so out_ready alone completes
        // the handshake; the next instruction issues in the same cycle.
        if (out_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cnt        <= '0;
      cu_in      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_op     <= '0;
      acc        <= '0;
    end else begin
      state <= state_nxt;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;

      // Issue stage: load the CU word and restart the settle count.
      if (pop) begin
        cu_in <= cu_word(head, acc);
        cnt   <= CNT_INIT;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      // Capture stage: sample the CU once its inputs have settled.
      if (capture) begin
        out_result <= cu_result;
        acc        <= cu_result;
        out_op     <= cu_in[18:16];
        out_valid  <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Queue storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: table-driven single-instruction vectors plus
// hand-written sequences for backpressure, simultaneous push/pop, settle
// timing (SETTLE_CYCLES=3 instance) and reset during execution.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [19:0] in_instr;
  logic [18:0] cu_in;
  logic [7:0]  cu_result, out_result, acc;
  logic [2:0]  out_op;
  logic [2:0]  fifo_count;

  logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  logic [19:0] in_instr3;
  logic [18:0] cu_in3;
  logic [7:0]  cu_result3, out_result3, acc3, cu3_xor;
  logic [2:0]  out_op3;
  logic [2:0]  fifo_count3;

  assign cu_result  = cu_in[15:8] + cu_in[7:0];
  assign cu_result3 = (cu_in3[15:8] + cu_in3[7:0]) ^ cu3_xor;

  alu_sequencer #(.DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .cu_in(cu_in), .cu_result(cu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_op(out_op), .acc(acc), .busy(busy), .fifo_count(fifo_count)
  );

  alu_sequencer #(.DEPTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_instr(in_instr3), .cu_in(cu_in3), .cu_result(cu_result3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_result(out_result3),
    .out_op(out_op3), .acc(acc3), .busy(busy3), .fifo_count(fifo_count3)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Results accepted by the consumer of the SETTLE_CYCLES=1 instance.
  logic [10:0] got[$];
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back({out_op, out_result});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [7:0] model_res(input logic [19:0] ins, input logic [7:0] a);
    logic [7:0] op1;
    op1 = ins[19] ? a : ins[15:8];
    return op1 + ins[7:0];
  endfunction

  typedef struct {
    logic [19:0] instr;
    logic [18:0] cu;
    logic [7:0]  res;
    logic [2:0]  op;
  } vec_t;

  vec_t        vecs[6];
  logic [19:0] bp[6];
  logic [19:0] sp[4];
  logic [7:0]  macc;
  bit          ok, stale;

  initial begin
    vecs[0] = '{instr: 20'h11234, cu: 19'h11234, res: 8'h46, op: 3'd1};
    vecs[1] = '{instr: 20'h1F020, cu: 19'h1F020, res: 8'h10, op: 3'd1};
    vecs[2] = '{instr: 20'hA0005, cu: 19'h21005, res: 8'h15, op: 3'd2};
    vecs[3] = '{instr: 20'h7FF01, cu: 19'h7FF01, res: 8'h00, op: 3'd7};
    vecs[4] = '{instr: 20'hBAA80, cu: 19'h30080, res: 8'h80, op: 3'd3};
    vecs[5] = '{instr: 20'h07F7F, cu: 19'h07F7F, res: 8'hFE, op: 3'd0};
    for (int i = 0; i < 6; i++) bp[i] = {1'b0, 3'(i), 8'(8'h20 * i + 1), 8'(8'h11 * i)};
    for (int i = 0; i < 4; i++) sp[i] = {1'b0, 3'(i + 4), 8'(8'h31 * i), 8'(8'h0F + i)};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_instr3 = '0; out_ready3 = 1'b1; cu3_xor = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_cu_in", 32'(cu_in), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Table: one instruction at a time, accumulator carried across entries
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      tick();
      in_valid = 1'b0;
      wait_out(ok);
      check($sformatf("vec%0d_timeout", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_cu_in", i), 32'(cu_in), 32'(vecs[i].cu));
      check($sformatf("vec%0d_result", i), 32'(out_result), 32'(vecs[i].res));
      check($sformatf("vec%0d_op", i), 32'(out_op), 32'(vecs[i].op));
      check($sformatf("vec%0d_acc", i), 32'(acc), 32'(vecs[i].res));
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_valid_pulse", i), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      tick();
    end

    // Backpressure: fill the queue with the consumer stalled
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = bp[i];
      @(negedge clk);
      check($sformatf("bp%0d_ready", i), 32'(in_ready), 32'd1);
      tick();
    end
    in_instr = bp[5];
    @(negedge clk);
    check("bp_full_count", 32'(fifo_count), 32'd4);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_first_valid", 32'(out_valid), 32'd1);
    tick(); tick(); tick();
    @(negedge clk);
    check("bp_hold_result", 32'(out_result), 32'(model_res(bp[0], 8'h00)));
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_count", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    check("bp_sixth_accepted", 32'(ok), 32'd1);
    wait_idle(ok);
    check("bp_drain_timeout", 32'(ok), 32'd1);
    check("bp_drain_count", 32'(got.size()), 32'd6);
    macc = 8'h00;
    for (int i = 0; i < 6; i++) begin
      macc = model_res(bp[i], macc);
      if (i < got.size())
        check($sformatf("bp_order%0d", i), 32'(got[i]), 32'({bp[i][18:16], macc}));
    end

    // Simultaneous push and pop with two entries queued
    tick();
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = sp[i];
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("sp_pre_count", 32'(fifo_count), 32'd2);
    check("sp_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_instr = sp[3];
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("sp_count_kept", 32'(fifo_count), 32'd2);
    wait_idle(ok);
    check("sp_drain_timeout", 32'(ok), 32'd1);
    check("sp_drain_count", 32'(got.size()), 32'd4);
    macc = 8'h00;
    for (int i = 0; i < 4; i++) begin
      macc = model_res(sp[i], macc);
      if (i < got.size())
        check($sformatf("sp_order%0d", i), 32'(got[i]), 32'({sp[i][18:16], macc}));
    end

    // Settle timing on the SETTLE_CYCLES=3 instance
    tick();
    in_valid3 = 1'b1;
    in_instr3 = 20'h53344;
    tick();                       // push
    in_valid3 = 1'b0;
    tick();                       // pop, cu_in loaded
    cu3_xor = 8'hFF;              // disturb the CU before the sample point
    @(negedge clk);
    check("settle_c1_cu_in", 32'(cu_in3), 32'h53344);
    check("settle_c1_valid", 32'(out_valid3), 32'd0);
    tick();
    @(negedge clk);
    check("settle_c2_cu_in", 32'(cu_in3), 32'h53344);
    check("settle_c2_valid", 32'(out_valid3), 32'd0);
    tick();
    cu3_xor = 8'h00;
    @(negedge clk);
    check("settle_c3_cu_in", 32'(cu_in3), 32'h53344);
    check("settle_c3_valid", 32'(out_valid3), 32'd0);
    tick();
    @(negedge clk);
    check("settle_c4_valid", 32'(out_valid3), 32'd1);
    check("settle_result", 32'(out_result3), 32'h77);
    check("settle_op", 32'(out_op3), 32'd5);
    tick();
    @(negedge clk);
    check("settle_valid_drop", 32'(out_valid3), 32'd0);

    // Reset while executing with two instructions queued
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = bp[i];
      tick();
    end
    in_instr = bp[3];
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("rx_pre_count", 32'(fifo_count), 32'd2);
    check("rx_pre_busy", 32'(busy), 32'd1);
    got.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rx_out_valid", 32'(out_valid), 32'd0);
    check("rx_count", 32'(fifo_count), 32'd0);
    check("rx_acc", 32'(acc), 32'd0);
    check("rx_cu_in", 32'(cu_in), 32'd0);
    check("rx_busy", 32'(busy), 32'd0);
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("rx_no_stale", 32'(stale), 32'd0);
    check("rx_no_result", 32'(got.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
